// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux arbiter.
// Used by mux4_rr_arbiter (optional ARB_TIMEOUT_EN hold limit) and mux4_sel.
package mux4_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int NREQ         = 4;
  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/mux4_sel.sv
// Plain WIDTH-bit 4:1 multiplexer indexed by a 2-bit select.
// Shared datapath owned by whichever requester the arbiter grants.
module mux4_sel #(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      2'd0: y = i0;
      2'd1: y = i1;
      2'd2: y = i2;
      2'd3: y = i3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 mux; gnt/sel/busy registered.
// Define ARB_TIMEOUT_EN to cap consecutive grant cycles at MAX_HOLD.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [WIDTH-1:0] y
);

  arb_state_e state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;

  logic       grant_en;
  logic [1:0] grant_idx;
  logic [2:0] pick;
  logic [WIDTH-1:0] mux_y;

  // First set bit of r after base, wrapping; base itself is tried last.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(
    input logic [1:0] base,
    input logic [3:0] r
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int o = NREQ; o >= 1; o--) begin
      idx = base + 2'(o);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt_q, cnt_d;
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    grant_en  = 1'b0;
    grant_idx = sel_q;
    pick      = 3'b000;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        pick      = rr_pick(ptr_q, req);
        grant_en  = pick[2];
        grant_idx = pick[1:0];
      end
      ST_OWNED: begin
        if (!req[sel_q]) begin
          pick      = rr_pick(sel_q, req);
          grant_en  = pick[2];
          grant_idx = pick[1:0];
          if (!pick[2]) begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          // Owner still requesting: force a handoff once the hold limit hits.
          if (cnt_q == HOLD_LAST) begin
            pick      = rr_pick(sel_q, req & ~(4'b0001 << sel_q));
            grant_en  = pick[2];
            grant_idx = pick[1:0];
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (grant_en) begin
      state_d = ST_OWNED;
      gnt_d   = 4'b0001 << grant_idx;
      sel_d   = grant_idx;
      ptr_d   = grant_idx;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  mux4_sel #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(sel_q),
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .y  (mux_y)
  );

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = (state_q == ST_OWNED);
  assign y    = busy ? mux_y : '0;

endmodule
